// File: rtl/dbnc_scan_ctrl.sv
// Time-multiplexed debouncer: one shared stability counter qualifies changed inputs in round-robin order.
// Optional DBNC_SYNC_EN inserts a 2-flop synchroniser per input ahead of the mismatch compare.
module dbnc_scan_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned CNT_MAX = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        btn_in,
  output logic [N-1:0]                        btn_level,
  output logic [N-1:0]                        btn_press,
  output logic [N-1:0]                        btn_release,
  output logic                                busy,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] cur_idx
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       level_q, level_d;
  logic [N-1:0]       press_q, press_d;
  logic [N-1:0]       release_q, release_d;
  logic               busy_q, busy_d;
  logic [N-1:0]       samp;
  logic [N-1:0]       mis;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;

`ifdef DBNC_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = btn_in;
`endif

  assign mis = samp ^ level_q;

  // Round-robin search starting just after the last serviced index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!grant_found && mis[IDX_W'((32'(ptr_q) + k) % N)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((32'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          idx_d   = grant_idx;
          cnt_d   = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!mis[idx_q]) begin
          cnt_d   = '0;
          ptr_d   = idx_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(CNT_MAX - 1)) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        level_d[idx_q]   = ~level_q[idx_q];
        press_d[idx_q]   = ~level_q[idx_q];
        release_d[idx_q] = level_q[idx_q];
        ptr_d            = idx_q;
        cnt_d            = '0;
        state_d          = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(N - 1);
      idx_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= busy_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign busy        = busy_q;
  assign cur_idx     = idx_q;

endmodule
